// File: rtl/lea_pkg.sv
// Shared definitions for the LEA decryption round sequencer: state
// encoding, round counts per key size and key-select codes.
package lea_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    localparam int NR_128 = 24;
    localparam int NR_192 = 28;
    localparam int NR_256 = 32;

    localparam logic [1:0] KEY_SEL_128 = 2'd0;
    localparam logic [1:0] KEY_SEL_192 = 2'd1;
    localparam logic [1:0] KEY_SEL_256 = 2'd2;
    localparam logic [1:0] KEY_SEL_BAD = 2'd3;

    // Number of rounds for a legal key size; the illegal code never reaches
    // a caller that uses the result, so it simply falls back to the 128-bit count.
    function automatic int rounds_for_key(input logic [1:0] key_sel);
        case (key_sel)
            KEY_SEL_192: return NR_192;
            KEY_SEL_256: return NR_256;
            default:     return NR_128;
        endcase
    endfunction

endpackage

// File: rtl/lea_sat_counter.sv
// Clear/enable up-counter that sticks at its all-ones value instead of
// wrapping, used to report elapsed cycles of a decryption run.
module lea_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    // Clear wins over enable; once all ones the count stops moving.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/lea_dec_round_seq.sv
// Round sequencer for the LEA decryption datapath: after a start request it
// issues a load pulse, then round indices Nr-1 down to 0 under a
// round_ready handshake, then a done pulse. Also tracks elapsed cycles.
module lea_dec_round_seq
    import lea_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int RIDX_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        key_sel,
    input  logic              abort,
    input  logic              round_ready,
    output logic              busy,
    output logic              load_en,
    output logic              round_en,
    output logic [RIDX_W-1:0] round_idx,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  cycle_cnt
);

    seq_state_t        state;
    seq_state_t        next_state;
    logic [RIDX_W-1:0] first_idx;
    logic              accept;
    logic              count_en;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and decoded outputs; abort overrides everything while busy
    // and also suppresses the round enable and cycle counting that cycle.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        load_en    = 1'b0;
        round_en   = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        count_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && (key_sel != KEY_SEL_BAD)) begin
                    accept     = 1'b1;
                    next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy    = 1'b1;
                load_en = 1'b1;
                if (abort) begin
                    next_state = ST_IDLE;
                end else begin
                    count_en   = 1'b1;
                    next_state = ST_ROUND;
                end
            end
            ST_ROUND: begin
                busy = 1'b1;
                if (abort) begin
                    next_state = ST_IDLE;
                end else begin
                    count_en = 1'b1;
                    round_en = round_ready;
                    if (round_ready && (round_idx == '0)) begin
                        next_state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Capture the starting round index when a legal start is accepted, so
    // later key_sel changes cannot disturb the running operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_idx <= '0;
        end else if (accept) begin
            first_idx <= RIDX_W'(rounds_for_key(key_sel) - 1);
        end
    end

    // Round index down-counter: loaded in LOAD, stepped on each executed
    // round, parked at zero when an operation is aborted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            round_idx <= '0;
        end else if (busy && abort) begin
            round_idx <= '0;
        end else if (load_en) begin
            round_idx <= first_idx;
        end else if (round_en && (round_idx != '0)) begin
            round_idx <= round_idx - RIDX_W'(1);
        end
    end

    // Illegal key request flagged for one cycle; only honoured from IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else begin
            err <= (state == ST_IDLE) && start && (key_sel == KEY_SEL_BAD);
        end
    end

    lea_sat_counter #(
        .W(CNT_W)
    ) u_cycle_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable (count_en),
        .count  (cycle_cnt)
    );

endmodule

// File: tb/tb_lea_dec_round_seq.sv
// Self-checking bench for lea_dec_round_seq: directed scenarios with
// hand-computed latencies plus randomized traffic, all outputs compared
// every cycle against a run-level behavioural model.
module tb_lea_dec_round_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] key_sel;
    logic       abort;
    logic       round_ready;
    logic       busy;
    logic       load_en;
    logic       round_en;
    logic [4:0] round_idx;
    logic       done;
    logic       err;
    logic [15:0] cycle_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase 0 idle, 1 load, 2 rounds, 3 done; progress kept as counts.
    int m_phase   = 0;
    int m_nr      = 0;
    int m_rounds  = 0;
    int m_elapsed = 0;
    bit m_err     = 1'b0;

    lea_dec_round_seq #(
        .CNT_W  (16),
        .RIDX_W (5)
    ) dut (
        .clk         (clk),
        .rst         (rst_n),
        .start       (start),
        .key_sel     (key_sel),
        .abort       (abort),
        .round_ready (round_ready),
        .busy        (busy),
        .load_en     (load_en),
        .round_en    (round_en),
        .round_idx   (round_idx),
        .done        (done),
        .err         (err),
        .cycle_cnt   (cycle_cnt)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model advanced once per clock edge from the sampled inputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase   = 0;
            m_nr      = 0;
            m_rounds  = 0;
            m_elapsed = 0;
            m_err     = 1'b0;
        end else begin
            m_err = 1'b0;
            case (m_phase)
                0: begin
                    if (start) begin
                        if (key_sel == 2'd3) begin
                            m_err = 1'b1;
                        end else begin
                            m_nr      = 24 + 4 * int'(key_sel);
                            m_rounds  = 0;
                            m_elapsed = 0;
                            m_phase   = 1;
                        end
                    end
                end
                1: begin
                    if (abort) m_phase = 0;
                    else begin
                        m_elapsed++;
                        m_phase = 2;
                    end
                end
                2: begin
                    if (abort) m_phase = 0;
                    else begin
                        m_elapsed++;
                        if (round_ready) begin
                            m_rounds++;
                            if (m_rounds == m_nr) m_phase = 3;
                        end
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        check_output("busy", int'(busy), int'(m_phase == 1 || m_phase == 2));
        check_output("load_en", int'(load_en), int'(m_phase == 1));
        check_output("round_en", int'(round_en), int'(m_phase == 2 && round_ready && !abort));
        check_output("round_idx", int'(round_idx), (m_phase == 2) ? (m_nr - 1 - m_rounds) : 0);
        check_output("done", int'(done), int'(m_phase == 3));
        check_output("err", int'(err), int'(m_err));
        check_output("cycle_cnt", int'(cycle_cnt), (m_elapsed > 65535) ? 65535 : m_elapsed);
    end

    // Run one operation; cycle 1 is the cycle after the edge that samples start.
    task automatic apply_stimulus(input int key, input int stall_idx, input int stall_len,
                                  input int abort_idx, input int max_cyc,
                                  output int done_cyc, output int rounds, output int loads,
                                  output int cnt_end, output bit saw_done);
        int cyc;
        int stall_left;
        bit aborted;
        bit finished;
        done_cyc   = 0;
        rounds     = 0;
        loads      = 0;
        cnt_end    = 0;
        saw_done   = 1'b0;
        stall_left = stall_len;
        aborted    = 1'b0;
        finished   = 1'b0;
        cyc        = 0;
        @(posedge clk); #1;
        start = 1'b1; key_sel = 2'(key); abort = 1'b0; round_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!finished && cyc <= max_cyc) begin
            abort = 1'b0;
            round_ready = 1'b1;
            if (busy && !load_en) begin
                if (!aborted && abort_idx >= 0 && int'(round_idx) == abort_idx) begin
                    abort = 1'b1;
                    aborted = 1'b1;
                end else if (int'(round_idx) == stall_idx && stall_left > 0) begin
                    round_ready = 1'b0;
                    stall_left--;
                end
            end
            #3;
            if (load_en) loads++;
            if (round_en) rounds++;
            if (done) begin
                saw_done = 1'b1;
                done_cyc = cyc;
                cnt_end  = int'(cycle_cnt);
                finished = 1'b1;
            end else if (aborted && !busy) begin
                cnt_end  = int'(cycle_cnt);
                finished = 1'b1;
            end
            if (!finished) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!finished) check_output("op_timeout", 0, 1);
        abort = 1'b0;
        round_ready = 1'b1;
    endtask

    initial begin
        int dc, rn, ld, ce;
        bit sd;
        rst_n = 1'b0;
        start = 1'b0;
        key_sel = 2'd0;
        abort = 1'b0;
        round_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_idx", int'(round_idx), 0);
        check_output("reset_cnt", int'(cycle_cnt), 0);
        rst_n = 1'b1;

        // 128-bit key, no stalls.
        apply_stimulus(0, -1, 0, -1, 200, dc, rn, ld, ce, sd);
        check_output("k128_done_cycle", dc, 26);
        check_output("k128_cnt", ce, 25);
        check_output("k128_rounds", rn, 24);
        check_output("k128_loads", ld, 1);

        // Illegal key select: error pulse only.
        @(posedge clk); #1;
        start = 1'b1; key_sel = 2'd3;
        @(posedge clk); #1;
        start = 1'b0;
        #3;
        check_output("bad_err", int'(err), 1);
        check_output("bad_busy", int'(busy), 0);
        check_output("bad_load", int'(load_en), 0);
        check_output("bad_cnt", int'(cycle_cnt), 25);
        @(posedge clk); #4;
        check_output("bad_err_clear", int'(err), 0);

        // 256-bit key with a 3-cycle stall at index 10.
        apply_stimulus(2, 10, 3, -1, 200, dc, rn, ld, ce, sd);
        check_output("k256_done_cycle", dc, 37);
        check_output("k256_cnt", ce, 36);
        check_output("k256_rounds", rn, 32);

        // 192-bit key aborted at index 15, then a clean rerun.
        apply_stimulus(1, -1, 0, 15, 200, dc, rn, ld, ce, sd);
        check_output("abort_no_done", int'(sd), 0);
        check_output("abort_idx", int'(round_idx), 0);
        check_output("abort_cnt", ce, 13);
        check_output("abort_rounds", rn, 12);
        apply_stimulus(1, -1, 0, -1, 200, dc, rn, ld, ce, sd);
        check_output("k192_done_cycle", dc, 30);
        check_output("k192_cnt", ce, 29);
        check_output("k192_rounds", rn, 28);

        // Busy-time start pulses ignored, then async reset between edges.
        @(posedge clk); #1;
        start = 1'b1; key_sel = 2'd0; round_ready = 1'b1;
        @(posedge clk); #1;
        repeat (8) begin
            start = 1'b1; key_sel = 2'd3;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check_output("busy_before_rst", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_busy", int'(busy), 0);
        check_output("async_idx", int'(round_idx), 0);
        check_output("async_cnt", int'(cycle_cnt), 0);
        check_output("async_round_en", int'(round_en), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Long stall saturates the cycle counter.
        apply_stimulus(0, 20, 70000, -1, 80000, dc, rn, ld, ce, sd);
        check_output("sat_cnt", ce, 65535);
        check_output("sat_done_cycle", dc, 70026);
        check_output("sat_rounds", rn, 24);

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            start       = ($urandom_range(0, 3) == 0);
            key_sel     = 2'($urandom_range(0, 3));
            abort       = ($urandom_range(0, 29) == 0);
            round_ready = ($urandom_range(0, 9) < 7);
        end
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; round_ready = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check_output("final_idle", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
